// File: rtl/moving_average_pkg.sv
// moving_average_pkg: shared state enum, window-select width and helpers for the moving-average filter
package moving_average_pkg;
  localparam int POW_W = 3;
  typedef enum logic {FILL, RUN} state_e;
  function automatic logic [POW_W-1:0] clamp_pow(input logic [POW_W-1:0] p, input int max_p);
    return (int'(p) > max_p) ? POW_W'(max_p) : p;
  endfunction
  function automatic int acc_w(input int data_w, input int max_power);
    return data_w + max_power;
  endfunction
endpackage

// File: rtl/ma_sample_ring.sv
// ma_sample_ring: D x DATA_W sample store, one write port, one asynchronous read port, no reset
module ma_sample_ring #(
  parameter int DATA_W = 10,
  parameter int MAX_POWER = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [MAX_POWER-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [MAX_POWER-1:0] raddr_i,
  output logic [DATA_W-1:0]    rdata_o
);
  logic [DATA_W-1:0] mem_q [2**MAX_POWER];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/moving_average_configurable.sv
// moving_average_configurable: power-of-two moving average with run-time window, warm-up
// qualification, flush on window change and optional half-up rounding
module moving_average_configurable
  import moving_average_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int MAX_POWER = 4,
  parameter int ROUND = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              strobe_i,
  input  logic [POW_W-1:0]  pow_i,
  output logic [DATA_W-1:0] data_o,
  output logic              strobe_o,
  output logic              valid_o,
  output logic [POW_W-1:0]  pow_o
);
  localparam int AW = acc_w(DATA_W, MAX_POWER);
  logic [AW-1:0] acc_q, acc_d;
  logic [MAX_POWER:0] cnt_q, cnt_d, n;
  logic [MAX_POWER-1:0] wp_q, wp_d;
  logic [POW_W-1:0] pow_q, pow_d;
  state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data;
  logic strobe_q, flush, full;
  logic [AW:0] sum, quo;
  assign n = (MAX_POWER+1)'(1) << pow_q;
  assign pow_d = clamp_pow(pow_i, MAX_POWER);
  assign flush = pow_d != pow_q;
  assign full = cnt_q >= n;
  // for N = D the read index equals wp, so the oldest sample is read before it is overwritten
  ma_sample_ring #(.DATA_W(DATA_W), .MAX_POWER(MAX_POWER)) u_ring (
    .clk(clk),
    .we_i(strobe_i),
    .waddr_i(wp_q),
    .wdata_i(data_i),
    .raddr_i(wp_q - n[MAX_POWER-1:0]),
    .rdata_o(rd_data)
  );
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    state_d = state_q;
    wp_d = wp_q + MAX_POWER'(strobe_i);
    if (flush) begin
      acc_d = strobe_i ? AW'(data_i) : '0;
      cnt_d = {{MAX_POWER{1'b0}}, strobe_i};
      state_d = (strobe_i && pow_d == '0) ? RUN : FILL;
    end else if (strobe_i) begin
      acc_d = acc_q + AW'(data_i) - (full ? AW'(rd_data) : '0);
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
      state_d = (cnt_d == n) ? RUN : state_q;
    end
    sum = {1'b0, acc_d} + ((ROUND != 0 && pow_d != '0) ? (AW+1)'(1) << (pow_d - 1'b1) : '0);
    quo = sum >> pow_d;
    data_d = strobe_i ? ((quo > (AW+1)'({DATA_W{1'b1}})) ? '1 : quo[DATA_W-1:0]) : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      pow_q <= '0;
      state_q <= FILL;
      data_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      pow_q <= pow_d;
      state_q <= state_d;
      data_q <= data_d;
      strobe_q <= strobe_i;
    end
  assign data_o = data_q;
  assign strobe_o = strobe_q;
  assign valid_o = state_q == RUN;
  assign pow_o = pow_q;
endmodule

// File: tb/tb_moving_average_configurable.sv
// tb_moving_average_configurable: vector table plus history-based scoreboard for both rounding modes
module tb_moving_average_configurable;
  logic clk = 1'b0, rst_n = 1'b0, strobe_i = 1'b0;
  logic [9:0] data_i = '0;
  logic [2:0] pow_i = '0;
  logic [9:0] data_o, data_r;
  logic strobe_o, strobe_r, valid_o, valid_r;
  logic [2:0] pow_o, pow_r;
  int pass = 0, total = 0;
  typedef struct { int d; int r; int v; } exp_t;
  exp_t sb[$];
  int hist[$];
  int mpow = 0;
  typedef struct { int p; int d; int ed; int ev; } vec_t;
  vec_t vt[];

  always #5 clk = ~clk;

  moving_average_configurable #(.DATA_W(10), .MAX_POWER(4), .ROUND(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .strobe_i(strobe_i), .pow_i(pow_i),
    .data_o(data_o), .strobe_o(strobe_o), .valid_o(valid_o), .pow_o(pow_o));
  moving_average_configurable #(.DATA_W(10), .MAX_POWER(4), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .strobe_i(strobe_i), .pow_i(pow_i),
    .data_o(data_r), .strobe_o(strobe_r), .valid_o(valid_r), .pow_o(pow_r));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input int p, input bit s, input int d);
    int c, n, sum, k;
    exp_t e;
    @(negedge clk);
    pow_i = 3'(p);
    strobe_i = s;
    data_i = 10'(d);
    c = (p > 4) ? 4 : p;
    if (c != mpow) begin
      hist.delete();
      mpow = c;
    end
    if (s) begin
      hist.push_back(d);
      if (hist.size() > 16) void'(hist.pop_front());
      n = 1 << mpow;
      sum = 0;
      k = 0;
      for (int i = hist.size() - 1; i >= 0 && k < n; i--) begin
        sum += hist[i];
        k++;
      end
      e.d = sum >> mpow;
      e.r = (mpow > 0) ? ((sum + (1 << (mpow - 1))) >> mpow) : sum;
      if (e.r > 1023) e.r = 1023;
      e.v = (hist.size() >= n) ? 1 : 0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs();
    foreach (vt[i]) begin
      drive(vt[i].p, 1'b1, vt[i].d);
      chk($sformatf("vec%0d_data", i), int'(data_o), vt[i].ed);
      chk($sformatf("vec%0d_valid", i), int'(valid_o), vt[i].ev);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && strobe_o) begin
      if (sb.size() == 0) chk("sb_unexpected_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_data", int'(data_o), e.d);
        chk("sb_round", int'(data_r), e.r);
        chk("sb_valid", int'(valid_o), e.v);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", int'(data_o), 0);
    chk("rst_strobe", int'(strobe_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_pow", int'(pow_o), 0);
    @(negedge clk) rst_n = 1'b1;
    vt = '{'{2, 4, 1, 0}, '{2, 8, 3, 0}, '{2, 12, 6, 0}, '{2, 16, 10, 1}, '{2, 20, 14, 1},
           '{0, 5, 5, 1}, '{0, 1023, 1023, 1}};
    run_vecs();
    drive(0, 1'b0, 0);
    chk("idle_strobe", int'(strobe_o), 0);
    chk("idle_hold", int'(data_o), 1023);
    for (int i = 0; i < 15; i++) drive(4, 1'b1, 1023);
    chk("pow4_warm_valid", int'(valid_o), 0);
    drive(4, 1'b1, 1023);
    chk("pow4_full_data", int'(data_o), 1023);
    chk("pow4_full_valid", int'(valid_o), 1);
    for (int i = 0; i < 40; i++) drive(4, 1'b1, int'($urandom_range(0, 1023)));
    drive(5, 1'b0, 0);
    chk("clamp_pow_o", int'(pow_o), 4);
    chk("clamp_no_flush_valid", int'(valid_o), 1);
    drive(7, 1'b0, 0);
    chk("clamp7_pow_o", int'(pow_o), 4);
    drive(3, 1'b0, 0);
    chk("pow_o_no_strobe", int'(pow_o), 3);
    chk("flush_valid_drop", int'(valid_o), 0);
    for (int i = 0; i < 8; i++) drive(3, 1'b1, int'($urandom_range(0, 1023)));
    chk("pow3_run", int'(valid_o), 1);
    vt = '{'{1, 6, 3, 0}, '{1, 2, 4, 1}};
    run_vecs();
    drive(2, 1'b0, 0);
    drive(1, 1'b1, 1);
    chk("trunc_half", int'(data_o), 0);
    chk("round_half", int'(data_r), 1);
    drive(1, 1'b1, 2);
    chk("trunc_1p5", int'(data_o), 1);
    chk("round_1p5", int'(data_r), 2);
    for (int i = 0; i < 20; i++) drive(int'($urandom_range(0, 4)), 1'(($urandom_range(0, 3)) != 0), int'($urandom_range(0, 1023)));
    drive(2, 1'b1, 100);
    drive(2, 1'b1, 100);
    drive(2, 1'b0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_data", int'(data_o), 0);
    chk("async_rst_valid", int'(valid_o), 0);
    chk("async_rst_pow", int'(pow_o), 0);
    sb.delete();
    hist.delete();
    mpow = 0;
    @(negedge clk) rst_n = 1'b1;
    vt = '{'{2, 8, 2, 0}, '{2, 8, 4, 0}, '{2, 8, 6, 0}, '{2, 8, 8, 1}};
    run_vecs();
    drive(2, 1'b0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/moving_average_configurable.md
# moving_average_configurable

Single-channel moving-average filter with a run-time-selectable power-of-two window of 1 to 2^MAX_POWER samples. It replaces the current set of fixed-window filters plus output mux with one shared sample ring and one running accumulator. It sits between the strobe-qualified sample input pins and the output pins. It adds warm-up qualification, automatic flush on window change, and optional rounding.

## Interface
- DATA_W, 10, sample width (unsigned)
- MAX_POWER, 4, log2 of the largest window; ring depth D = 2^MAX_POWER
- ROUND, 0, 0 = truncate quotient, 1 = round half-up
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_i  input  DATA_W  sample, qualified by strobe_i
- strobe_i  input  1  one-cycle sample-valid pulse; any duty cycle, back-to-back allowed
- pow_i  input  3  window select: N = 2^pow_i; values above MAX_POWER clamp to MAX_POWER
- data_o  output  DATA_W  filtered sample, registered
- strobe_o  output  1  one-cycle pulse marking a new data_o
- valid_o  output  1  high while the current window holds N real samples
- pow_o  output  3  clamped window power currently in effect

## Operation
- State: accumulator acc, DATA_W+MAX_POWER bits; ring of D samples; write pointer wp, MAX_POWER bits, wraps modulo D; fill count cnt, 0..D saturating; pow_q; FSM state FILL/RUN.
- On strobe_i:
  - Write data_i to ring[wp], then wp <= wp+1.
  - If cnt ≥ N: acc <= acc + data_i − ring[wp − N mod D]. Otherwise acc <= acc + data_i and cnt <= cnt+1.
- Output: q = acc >> pow_q. With ROUND=1 and pow_q>0, q = (acc + 2^(pow_q−1)) >> pow_q, saturated to 2^DATA_W−1.
- During warm-up, missing samples count as zero. Output ramps up; it is not divided by cnt.
- FSM:
  - FILL → RUN when cnt reaches N (on the strobe that makes cnt = N).
  - RUN holds until a flush.
  - valid_o = (state == RUN), registered with data_o.
- Flush trigger: clamp(pow_i) ≠ pow_q on any cycle. Flush action: pow_q <= clamp(pow_i), acc <= 0, cnt <= 0, state <= FILL. wp and ring contents are kept; stale entries are never read because cnt gates the subtraction.
- Flush and strobe_i in the same cycle: the sample is the first sample of the new window. acc <= data_i, cnt <= 1, strobe_o fires with q computed under the new pow. If the new N = 1, state goes straight to RUN.
- N = 1 (pow 0): data_o follows data_i with one cycle of latency, and valid_o is high from the first strobe.
- Arithmetic is unsigned. acc never overflows, since acc ≤ N·(2^DATA_W−1).

## Timing
- Latency: data_o, strobe_o and valid_o update one clk after the strobe_i edge.
- strobe_o is high for exactly one cycle per input strobe. data_o holds between strobes.
- pow_o updates one cycle after pow_i changes, even without a strobe.
- Reset (rst_n low, asynchronous, at any time including mid-window):
  - data_o = 0, strobe_o = 0, valid_o = 0.
  - pow_o = clamp(0) = 0.
  - acc = 0, cnt = 0, wp = 0, state FILL.
  - Ring contents are not reset.
- The first strobe after reset release is processed normally. A pow_i differing from 0 at release triggers a flush on the first clock.

## Structure
- Package moving_average_pkg holds:
  - FSM state enum (FILL, RUN)
  - the pow_i width constant
  - clamp function
  - accumulator-width helper (DATA_W+MAX_POWER)
- Sub-module ma_sample_ring: D×DATA_W register array with one write port and one asynchronous read port at wp − N. It has no reset.
- The top level holds acc, cnt, FSM, flush detection, divide/round and output registers.

## Test plan
- pow_i=2, defaults; strobes with 4,8,12,16,20 → data_o 1,3,6,10,14; valid_o rises with the 4th output (10).
- pow_i=0; strobe 5 then 1023 → data_o 5 then 1023, each 1 cycle after its strobe; valid_o high from the first output.
- pow_i=4 after 16 strobes of 1023 → data_o 1023 and valid_o=1. Continuous strobe every cycle for 40 samples checks wrap-around. Ring-index error → mismatch with the reference model.
- In RUN at pow 3, change pow_i to 1 with a simultaneous strobe of 6 → data_o 3, valid_o 0. Next strobe 2 → data_o 4, valid_o 1.
- ROUND=1, pow 1; samples 1,2 → data_o 1 (round of 0.5) then 2 (round of 1.5). ROUND=0 same samples → 0,1.
- Assert rst_n low mid-window, asynchronously between edges → outputs are 0 immediately. After release with pow 2, samples 8,8,8,8 → 2,4,6,8 with no residue from before reset.
